uart_transmitter: RTL and testbench

//  Serialises parallel bytes onto the UART line; direct upstream partner of the

---
 rtl/uart_transmitter.sv | 146 ++++++++++++++
 tb/tb_uart_transmitter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmit stage: start bit, DATA_W data bits MSB first, STOP_BITS stop bits.
// A one-entry holding register lets the source queue the next byte during a frame.
//
//   state | meaning
//   IDLE  | line high, waiting for a byte (direct load or from hold)
//   START | start bit (0) on the line
//   DATA  | data bits, MSB first, bit_cnt counts down to 0
//   STOP  | stop bit(s) (1), bit_cnt counts remaining stop bits
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIN,
    input  logic              Valid,
    output logic              Ready,
    output logic              tx,
    output logic              Busy
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] T_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_DATA   = CW'(DATA_W - 1);
    localparam logic [CW-1:0] C_STOP   = CW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;
    logic [CW-1:0]     bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [DATA_W-1:0] hold, hold_nxt;
    logic              hold_valid, hold_valid_nxt;
    logic              tx_nxt;
    logic              accept;
    logic              bit_end;
    logic              loaded_direct;

    assign Ready = !hold_valid;
    assign Busy  = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift;
        hold_nxt       = hold;
        hold_valid_nxt = hold_valid;
        loaded_direct  = 1'b0;
        accept         = Valid && !hold_valid;
        bit_end        = (timer == '0);
        timer_nxt      = bit_end ? timer : timer - TW'(1);

        case (state)
            IDLE: begin
                if (hold_valid) begin
                    shift_nxt      = hold;
                    hold_valid_nxt = 1'b0;
                    state_nxt      = START;
                    timer_nxt      = T_RELOAD;
                end else if (accept) begin
                    shift_nxt     = DataIN;
                    loaded_direct = 1'b1;
                    state_nxt     = START;
                    timer_nxt     = T_RELOAD;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = C_DATA;
                    timer_nxt   = T_RELOAD;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift << 1;
                    timer_nxt = T_RELOAD;
                    if (bit_cnt == '0) begin
                        state_nxt   = STOP;
                        bit_cnt_nxt = C_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt - CW'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt != '0) begin
                        bit_cnt_nxt = bit_cnt - CW'(1);
                        timer_nxt   = T_RELOAD;
                    end else if (hold_valid) begin
                        // back-to-back: next frame's start bit follows the last stop bit
                        shift_nxt      = hold;
                        hold_valid_nxt = 1'b0;
                        state_nxt      = START;
                        timer_nxt      = T_RELOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // accept needs an empty hold, so it never collides with a drain above
        if (accept && !loaded_direct) begin
            hold_nxt       = DataIN;
            hold_valid_nxt = 1'b1;
        end

        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[DATA_W-1];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            tx         <= 1'b1;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
            hold       <= hold_nxt;
            hold_valid <= hold_valid_nxt;
            tx         <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: two instances (1 clk/bit 1 stop, 4 clk/bit 2 stop)
// checked cycle by cycle against a frame-schedule reference model.
module tb_uart_transmitter;

    logic       CLK = 1'b0;
    logic       rst   [2];
    logic       valid [2];
    logic [7:0] din   [2];
    logic       rdy   [2];
    logic       txl   [2];
    logic       bsy   [2];

    int n_chk = 0;
    int n_bad = 0;
    int k = 0;
    int busy_run [2];

    // reference model: the last two scheduled frames per instance (start cycle + byte)
    bit         have_l [2];
    bit         have_p [2];
    int         st_l   [2];
    int         st_p   [2];
    logic [7:0] by_l   [2];
    logic [7:0] by_p   [2];

    always #5 CLK = ~CLK;
    always @(posedge CLK) k <= k + 1;

    uart_transmitter #(.CLKS_PER_BIT(1), .DATA_W(8), .STOP_BITS(1)) dut_a (
        .CLK(CLK), .Reset(rst[0]), .DataIN(din[0]), .Valid(valid[0]),
        .Ready(rdy[0]), .tx(txl[0]), .Busy(bsy[0])
    );

    uart_transmitter #(.CLKS_PER_BIT(4), .DATA_W(8), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .Reset(rst[1]), .DataIN(din[1]), .Valid(valid[1]),
        .Ready(rdy[1]), .tx(txl[1]), .Busy(bsy[1])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    function automatic int cpb(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int flen(input int i);
        return (1 + 8 + ((i == 0) ? 1 : 2)) * cpb(i);
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[8-idx];
        return 1'b1;
    endfunction

    function automatic bit covers(input int s, input int i, input int c);
        return (c >= s) && (c < s + flen(i));
    endfunction

    function automatic logic exp_tx(input int i, input int c);
        if (have_l[i] && covers(st_l[i], i, c)) return frame_bit(by_l[i], (c - st_l[i]) / cpb(i));
        if (have_p[i] && covers(st_p[i], i, c)) return frame_bit(by_p[i], (c - st_p[i]) / cpb(i));
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int i, input int c);
        return (have_l[i] && covers(st_l[i], i, c)) || (have_p[i] && covers(st_p[i], i, c));
    endfunction

    function automatic logic exp_ready(input int i, input int c);
        return !(have_l[i] && st_l[i] > c);
    endfunction

    task automatic model_clear(input int i);
        have_l[i] = 1'b0;
        have_p[i] = 1'b0;
    endtask

    // byte accepted on the edge closing cycle c: schedule its frame
    task automatic model_accept(input int i, input int c, input logic [7:0] b);
        int s;
        int last_end;
        last_end = st_l[i] + flen(i) - 1;
        if (!have_l[i] || last_end < c) s = c + 1;
        else if (last_end == c)         s = c + 2;
        else                            s = st_l[i] + flen(i);
        have_p[i] = have_l[i];
        st_p[i]   = st_l[i];
        by_p[i]   = by_l[i];
        have_l[i] = 1'b1;
        st_l[i]   = s;
        by_l[i]   = b;
    endtask

    task automatic tick(input int i, input bit v, input logic [7:0] d, output bit acc);
        @(negedge CLK);
        check_val($sformatf("tx%0d", i), 32'(txl[i]), 32'(exp_tx(i, k)));
        check_val($sformatf("ready%0d", i), 32'(rdy[i]), 32'(exp_ready(i, k)));
        check_val($sformatf("busy%0d", i), 32'(bsy[i]), 32'(exp_busy(i, k)));
        if (bsy[i] === 1'b1) busy_run[i]++;
        valid[i] = v;
        din[i]   = d;
        acc = v && exp_ready(i, k);
        if (acc) model_accept(i, k, d);
    endtask

    task automatic idle(input int i, input int n);
        bit acc;
        for (int c = 0; c < n; c++) tick(i, 1'b0, 8'h00, acc);
    endtask

    task automatic send(input int i, input logic [7:0] d);
        bit acc;
        acc = 1'b0;
        for (int c = 0; c < 200 && !acc; c++) tick(i, 1'b1, d, acc);
        if (!acc) check_val("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_now(input int i);
        @(negedge CLK);
        #1;
        rst[i]   = 1'b1;
        valid[i] = 1'b0;
        #1;
        check_val("rst_tx", 32'(txl[i]), 32'd1);
        check_val("rst_ready", 32'(rdy[i]), 32'd1);
        check_val("rst_busy", 32'(bsy[i]), 32'd0);
        model_clear(i);
        @(negedge CLK);
        @(negedge CLK);
        rst[i] = 1'b0;
    endtask

    initial begin
        bit acc;
        bit pend;
        logic [7:0] pd;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; valid[i] = 1'b0; din[i] = 8'h00; busy_run[i] = 0;
            model_clear(i); st_l[i] = 0; st_p[i] = 0; by_l[i] = 8'h00; by_p[i] = 8'h00;
        end
        repeat (3) @(negedge CLK);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        idle(0, 3);
        idle(1, 3);

        busy_run[0] = 0;
        send(0, 8'hA5);
        idle(0, 14);
        check_val("a5_busy_len", 32'(busy_run[0]), 32'd10);

        busy_run[0] = 0;
        send(0, 8'h3C);
        send(0, 8'hC3);
        idle(0, 25);
        check_val("b2b_busy_len", 32'(busy_run[0]), 32'd20);

        busy_run[1] = 0;
        send(1, 8'h81);
        idle(1, 50);
        check_val("x81_busy_len", 32'(busy_run[1]), 32'd44);

        send(0, 8'h11);
        send(0, 8'h22);
        idle(0, 2);
        check_val("hold_full_ready", 32'(rdy[0]), 32'd0);
        tick(0, 1'b1, 8'h55, acc);
        idle(0, 3);
        send(0, 8'h55);
        idle(0, 30);

        send(0, 8'h12);
        send(0, 8'h34);
        idle(0, 3);
        reset_now(0);
        idle(0, 25);

        reset_now(1);
        idle(1, 4);

        for (int i = 0; i < 2; i++) begin
            pend = 1'b0;
            pd   = 8'h00;
            for (int c = 0; c < ((i == 0) ? 400 : 900); c++) begin
                if (!pend && $urandom_range(0, 3) == 0) begin
                    pend = 1'b1;
                    pd   = 8'($urandom);
                end
                tick(i, pend, pd, acc);
                if (acc) pend = 1'b0;
            end
            idle(i, 2 * flen(i) + 4);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
